// File: rtl/prog_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_sequencer: loadable program memory with registered sequential fetch, |
// | jump, halt/resume and wrap flag; optional return stack (CALL_STACK_EN).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prog_sequencer #(
   parameter int INSTR_W     = 8,
   parameter int ADDR_W      = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ena,
   input  logic               halt_req,
   input  logic               resume,
   input  logic               jump_valid,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic               call_valid,
   input  logic               ret_valid,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               halted,
   output logic               wrap,
   output logic               stack_err
);

   localparam int         c_DEPTH = 2**ADDR_W;
   localparam logic [0:0] c_RUN   = 1'b0;
   localparam logic [0:0] c_HALT  = 1'b1;

   logic [INSTR_W-1:0] r_mem [c_DEPTH];
   logic [0:0]         r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_pc_out;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic               r_wrap;
   logic               w_fetch;
   logic [ADDR_W-1:0]  w_faddr;

   // Program memory is never reset; non-blocking write gives read-before-write.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   assign w_fetch = (r_state == c_RUN) && !halt_req && ena;

`ifdef CALL_STACK_EN
   localparam int                c_SP_W    = $clog2(STACK_DEPTH + 1);
   localparam int                c_IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [c_SP_W-1:0] c_SP_FULL = c_SP_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
   logic [c_SP_W-1:0]  r_sp;
   logic               r_stack_err;
   logic               w_push;
   logic               w_pop;
   logic               w_err;
   logic [c_IDX_W-1:0] w_push_idx;
   logic [c_IDX_W-1:0] w_pop_idx;

   assign w_push_idx = c_IDX_W'(r_sp);
   assign w_pop_idx  = c_IDX_W'(r_sp - c_SP_W'(1));

   always_comb begin
      w_faddr = r_pc;
      w_push  = 1'b0;
      w_pop   = 1'b0;
      w_err   = 1'b0;
      if (ret_valid) begin
         // An empty-stack return degrades to a plain sequential fetch.
         if (r_sp != '0) begin
            w_faddr = r_stack[w_pop_idx];
            w_pop   = 1'b1;
         end else begin
            w_err = 1'b1;
         end
      end else if (call_valid) begin
         w_faddr = jump_addr;
         if (r_sp != c_SP_FULL) begin
            w_push = 1'b1;
         end else begin
            w_err = 1'b1;
         end
      end else if (jump_valid) begin
         w_faddr = jump_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fetch && w_push) begin
         r_stack[w_push_idx] <= r_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp        <= '0;
         r_stack_err <= 1'b0;
      end else if (w_fetch) begin
         if (w_push) begin
            r_sp <= r_sp + c_SP_W'(1);
         end else if (w_pop) begin
            r_sp <= r_sp - c_SP_W'(1);
         end
         if (w_err) begin
            r_stack_err <= 1'b1;
         end
      end
   end

   assign stack_err = r_stack_err;
`else
   logic w_unused_ret;

   assign w_unused_ret = ret_valid | (STACK_DEPTH == 0);

   always_comb begin
      w_faddr = (call_valid || jump_valid) ? jump_addr : r_pc;
   end

   assign stack_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= c_RUN;
         r_pc     <= '0;
         r_instr  <= '0;
         r_valid  <= 1'b0;
         r_pc_out <= '0;
         r_wrap   <= 1'b0;
      end else begin
         if (r_state == c_RUN) begin
            if (halt_req) begin
               r_state <= c_HALT;
            end
         end else if (resume && !halt_req) begin
            r_state <= c_RUN;
         end
         r_valid <= w_fetch;
         r_wrap  <= w_fetch && (&w_faddr);
         if (w_fetch) begin
            r_instr  <= r_mem[w_faddr];
            r_pc_out <= w_faddr;
            r_pc     <= w_faddr + ADDR_W'(1);
         end
      end
   end

   assign instr_out   = r_instr;
   assign instr_valid = r_valid;
   assign pc_out      = r_pc_out;
   assign halted      = (r_state == c_HALT);
   assign wrap        = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prog_sequencer: directed table, corner sequences and random stimulus  |
// | against a behavioural model of prog_sequencer. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module tb_prog_sequencer;
   localparam int IW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int SD    = 4;

   logic          clk;
   logic          reset;
   logic          ena;
   logic          halt_req;
   logic          resume;
   logic          jump_valid;
   logic [AW-1:0] jump_addr;
   logic          call_valid;
   logic          ret_valid;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [IW-1:0] prog_data;
   logic [IW-1:0] instr_out;
   logic          instr_valid;
   logic [AW-1:0] pc_out;
   logic          halted;
   logic          wrap;
   logic          stack_err;

   prog_sequencer #(.INSTR_W(IW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
      .clk(clk), .reset(reset), .ena(ena), .halt_req(halt_req), .resume(resume),
      .jump_valid(jump_valid), .jump_addr(jump_addr), .call_valid(call_valid),
      .ret_valid(ret_valid), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .instr_out(instr_out), .instr_valid(instr_valid),
      .pc_out(pc_out), .halted(halted), .wrap(wrap), .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int m_mem [DEPTH];
   int m_pc, m_instr, m_pcout;
   bit m_halted, m_valid, m_wrap, m_err;
   int stk [$];

   typedef struct {
      logic          v_ena, v_hreq, v_res, v_jv;
      logic [AW-1:0] v_ja;
      logic          e_valid;
      logic [IW-1:0] e_instr;
      logic [AW-1:0] e_pc;
      logic          e_halted, e_wrap;
   } vec_t;
   vec_t vt [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_halted = 0; m_instr = 0; m_pcout = 0;
      m_valid = 0; m_wrap = 0; m_err = 0;
      stk.delete();
   endtask

   task automatic model_step();
      int f;
      bit fetch;
      if (reset) begin
         model_reset();
      end else begin
         fetch = !m_halted && !halt_req && ena;
         if (!m_halted && halt_req) m_halted = 1;
         else if (m_halted && resume && !halt_req) m_halted = 0;
         if (fetch) begin
            f = m_pc;
`ifdef CALL_STACK_EN
            if (ret_valid) begin
               if (stk.size() > 0) f = stk.pop_back();
               else m_err = 1;
            end else if (call_valid) begin
               if (stk.size() < SD) stk.push_back(m_pc);
               else m_err = 1;
               f = int'(jump_addr);
            end else if (jump_valid) begin
               f = int'(jump_addr);
            end
`else
            if (call_valid || jump_valid) f = int'(jump_addr);
`endif
            m_instr = m_mem[f];
            m_pcout = f;
            m_valid = 1;
            m_wrap  = (f == DEPTH - 1);
            m_pc    = (f + 1) % DEPTH;
         end else begin
            m_valid = 0;
            m_wrap  = 0;
         end
      end
      if (prog_we) m_mem[prog_addr] = int'(prog_data);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_ctrl();
      halt_req = 0; resume = 0; jump_valid = 0; jump_addr = '0;
      call_valid = 0; ret_valid = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_instr"}, instr_out, 0);
      check({tag, "_valid"}, instr_valid, 0);
      check({tag, "_pc"}, pc_out, 0);
      check({tag, "_halted"}, halted, 0);
      check({tag, "_wrap"}, wrap, 0);
      check({tag, "_serr"}, stack_err, 0);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_instr"}, instr_out, m_instr);
      check({tag, "_valid"}, instr_valid, m_valid);
      check({tag, "_pc"}, pc_out, m_pcout);
      check({tag, "_halted"}, halted, m_halted);
      check({tag, "_wrap"}, wrap, m_wrap);
      check({tag, "_serr"}, stack_err, m_err);
   endtask

   // Async reset pulse placed between clock edges.
   task automatic pulse_reset();
      #2 reset = 1;
      #1;
      #2 reset = 0;
      model_reset();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1; ena = 0;
      clear_ctrl();
      model_reset();
      #1;
      check_zero("reset");

      for (int i = 0; i < DEPTH; i++) begin
         prog_we = 1; prog_addr = AW'(i);
         case (i)
            0: prog_data = 8'h03;
            1: prog_data = 8'h22;
            2: prog_data = 8'h45;
            3: prog_data = 8'h00;
            default: prog_data = IW'(8'h10 + i);
         endcase
         tick();
      end
      clear_ctrl();
      reset = 0;

      vt[0]  = '{1, 0, 0, 0, 4'd0,  1, 8'h03, 4'd0,  0, 0};
      vt[1]  = '{1, 0, 0, 0, 4'd0,  1, 8'h22, 4'd1,  0, 0};
      vt[2]  = '{1, 0, 0, 0, 4'd0,  1, 8'h45, 4'd2,  0, 0};
      vt[3]  = '{1, 0, 0, 0, 4'd0,  1, 8'h00, 4'd3,  0, 0};
      vt[4]  = '{1, 0, 0, 0, 4'd0,  1, 8'h14, 4'd4,  0, 0};
      vt[5]  = '{1, 0, 0, 1, 4'd12, 1, 8'h1C, 4'd12, 0, 0};
      vt[6]  = '{1, 0, 0, 0, 4'd0,  1, 8'h1D, 4'd13, 0, 0};
      vt[7]  = '{0, 0, 0, 0, 4'd0,  0, 8'h1D, 4'd13, 0, 0};
      vt[8]  = '{0, 0, 0, 1, 4'd3,  0, 8'h1D, 4'd13, 0, 0};
      vt[9]  = '{1, 0, 0, 1, 4'd2,  1, 8'h45, 4'd2,  0, 0};
      vt[10] = '{1, 1, 0, 0, 4'd0,  0, 8'h45, 4'd2,  1, 0};
      vt[11] = '{1, 0, 0, 0, 4'd0,  0, 8'h45, 4'd2,  1, 0};
      vt[12] = '{1, 1, 1, 0, 4'd0,  0, 8'h45, 4'd2,  1, 0};
      vt[13] = '{1, 0, 1, 0, 4'd0,  0, 8'h45, 4'd2,  0, 0};
      vt[14] = '{1, 0, 0, 0, 4'd0,  1, 8'h00, 4'd3,  0, 0};
      vt[15] = '{1, 0, 0, 0, 4'd0,  1, 8'h14, 4'd4,  0, 0};

      for (int i = 0; i < 16; i++) begin
         ena = vt[i].v_ena; halt_req = vt[i].v_hreq; resume = vt[i].v_res;
         jump_valid = vt[i].v_jv; jump_addr = vt[i].v_ja;
         tick();
         check($sformatf("vec%0d", i), {instr_valid, instr_out, pc_out, halted, wrap},
               {vt[i].e_valid, vt[i].e_instr, vt[i].e_pc, vt[i].e_halted, vt[i].e_wrap});
      end
      clear_ctrl();

      // Full sweep from 0: wrap pulses only on the fetch of DEPTH-1.
      ena = 1;
      for (int i = 0; i <= DEPTH; i++) begin
         jump_valid = (i == 0); jump_addr = '0;
         tick();
         check($sformatf("wrap_pc%0d", i), pc_out, i % DEPTH);
         check($sformatf("wrap_flag%0d", i), wrap, (i == DEPTH - 1));
      end
      clear_ctrl();

      // Read-before-write on the fetched address, then refetch sees new data.
      jump_valid = 1; jump_addr = 4'd3;
      tick();
      check("rbw_pc3", pc_out, 3);
      jump_valid = 0; prog_we = 1; prog_addr = 4'd4; prog_data = 8'hA5;
      tick();
      check("rbw_old", instr_out, 8'h14);
      prog_we = 0; jump_valid = 1; jump_addr = 4'd4;
      tick();
      check("rbw_new", instr_out, 8'hA5);
      clear_ctrl();

`ifdef CALL_STACK_EN
      pulse_reset();
      ret_valid = 1;
      tick();
      check("ret_empty_pc", pc_out, 0);
      check("ret_empty_err", stack_err, 1);
      ret_valid = 0;

      pulse_reset();
      tick();
      tick();
      call_valid = 1; jump_addr = 4'd9;
      tick();
      check("call_pc", pc_out, 9);
      call_valid = 0; ret_valid = 1;
      tick();
      check("ret_pc", pc_out, 2);
      check("ret_err", stack_err, 0);
      ret_valid = 0;
      for (int k = 0; k < 5; k++) begin
         call_valid = 1; jump_addr = AW'(k + 8);
         tick();
         check($sformatf("nest%0d_pc", k), pc_out, k + 8);
         check($sformatf("nest%0d_err", k), stack_err, (k == 4));
      end
      clear_ctrl();
`endif

      for (int i = 0; i < 400; i++) begin
         ena        = ($urandom % 8) != 0;
         halt_req   = ($urandom % 12) == 0;
         resume     = ($urandom % 3) == 0;
         jump_valid = ($urandom % 5) == 0;
         call_valid = ($urandom % 7) == 0;
         ret_valid  = ($urandom % 6) == 0;
         jump_addr  = AW'($urandom);
         prog_we    = ($urandom % 4) == 0;
         prog_addr  = AW'($urandom);
         prog_data  = IW'($urandom);
         tick();
         check_model($sformatf("rnd%0d", i));
      end
      clear_ctrl();

      // Asynchronous reset mid-run: outputs clear without a clock edge.
      #2 reset = 1;
      #1;
      check_zero("async");
      #2 reset = 0;
      model_reset();
      ena = 1;
      tick();
      check("restart_pc", pc_out, 0);
      check("restart_valid", instr_valid, 1);
      check("restart_instr", instr_out, m_mem[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Parametrised successor to the mode-1 program counter + ROM.
- Holds a 2**ADDR_W x INSTR_W program memory, writable through a load port, and fetches sequentially.
- Adds registered fetch, jump, halt/resume, wrap flag and an optional call/return stack.
- Feeds the CPU decode stage in mode 1.

Parameters:
INSTR_W, 8, instruction width (opcode [INSTR_W-1:INSTR_W-3], operand below)
ADDR_W, 4, program address width; DEPTH = 2**ADDR_W
STACK_DEPTH, 4, return-stack entries (used only with CALL_STACK_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state except program memory
ena  in  1  fetch enable; one fetch per cycle when high and running
halt_req  in  1  enter HALT
resume  in  1  leave HALT
jump_valid  in  1  redirect fetch to jump_addr
jump_addr  in  ADDR_W  jump/call target
call_valid  in  1  call to jump_addr (CALL_STACK_EN)
ret_valid  in  1  return to popped address (CALL_STACK_EN)
prog_we  in  1  program memory write strobe
prog_addr  in  ADDR_W  write address
prog_data  in  INSTR_W  write data
instr_out  out  INSTR_W  fetched instruction (registered)
instr_valid  out  1  instr_out updated this cycle
pc_out  out  ADDR_W  address of instr_out
halted  out  1  state == HALT
wrap  out  1  one-cycle pulse when pc rolls DEPTH-1 -> 0
stack_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset values: pc=0, state=RUN, instr_out=0, instr_valid=0, pc_out=0, wrap=0, stack_err=0, stack pointer=0. Memory is not reset.
- Memory writes: prog_we writes mem[prog_addr]<=prog_data on any cycle, in any state.
- Same-cycle read of the written address returns old data (read-before-write).
- States: RUN, HALT.
  - RUN -> HALT on halt_req.
  - HALT -> RUN on resume while halt_req is low.
  - halt_req wins when both are high.
- A fetch occurs in a cycle when state==RUN, halt_req==0 and ena==1.
- Fetch address F:
  - ret_valid: popped address (valid pop only).
  - else call_valid or jump_valid: jump_addr.
  - else pc.
  - Priority is ret > call > jump > sequential.
- On a fetch: instr_out<=mem[F], pc_out<=F, pc<=F+1 mod DEPTH, instr_valid<=1.
- Latency: instruction appears one cycle after the fetch cycle.
- No fetch: instr_valid<=0; instr_out, pc_out and pc hold. Control inputs are ignored.
- wrap<=1 only in a fetch cycle with F==DEPTH-1; otherwise 0.
- The cycle in which halt_req rises produces no fetch.
- After resume, fetch continues from the held pc.
- Reset mid-operation: all outputs clear immediately (async); fetch restarts at address 0 on the first enabled cycle after release.

Optional Feature:
Macro `CALL_STACK_EN`.

Defined:
- Return stack of STACK_DEPTH x ADDR_W.
- call_valid on a fetch pushes pc (fall-through address) and fetches jump_addr.
- ret_valid pops and fetches the popped address.
- Push when full: no push, target still taken, stack_err<=1.
- Pop when empty: treated as sequential fetch (F=pc), stack_err<=1.
- stack_err clears only on reset.

Undefined:
- call_valid is treated as jump_valid.
- ret_valid is ignored.
- No stack storage; stack_err is tied 0.

Test Plan:
1. Load mem[0..3]=8'h03,8'h22,8'h45,8'h00; release reset; ena=1 -> instr_out 03,22,45,00 on cycles 1-4, pc_out 0..3, instr_valid=1.
2. Run 16 fetches from 0 -> fetch of address 15 gives wrap=1 for exactly one cycle; the next pc_out is 0.
3. At pc=5 assert jump_valid, jump_addr=12 -> next pc_out=12, then 13; ena low for 2 cycles -> instr_valid=0, outputs hold.
4. halt_req at pc=3 for 1 cycle -> halted=1, no fetches; resume with halt_req=1 -> stays halted; resume alone -> fetch resumes at pc_out=3.
5. CALL_STACK_EN, STACK_DEPTH=4:
   - call from pc=2 to 9, then ret -> pc_out 9 then 2.
   - 5 nested calls -> stack_err=1 on the 5th.
   - ret on empty after reset -> sequential fetch, stack_err=1.
6. prog_we to address 4 in the same cycle 4 is fetched -> old data on instr_out; the refetch after a jump to 4 returns the new data. Assert reset mid-run -> all outputs 0 asynchronously.
